// File: rtl/lif_param_serializer.sv
// Transmit side of the LIF neuron serial parameter-load link: snapshots a
// 7-byte parameter set and shifts it out MSB-first under a framing strobe.
module lif_param_serializer #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic [2:0] weight_a,
  input  logic [2:0] weight_b,
  input  logic [1:0] leak_config,
  input  logic [7:0] threshold_min,
  input  logic [7:0] threshold_max,
  input  logic [7:0] extra1,
  input  logic [7:0] extra2,
  output logic       serial_data_out,
  output logic       load_enable_out,
  output logic       busy,
  output logic       done,
  output logic       frame_parity
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam logic [5:0] LAST_BIT = 6'd55;
  localparam logic [5:0] GAP_LAST = 6'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [55:0] shreg_q, shreg_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sdata_q, sdata_d;
  logic        lden_q, lden_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        parity_q, parity_d;
  logic [55:0] payload;

  // Narrow fields are zero-padded at the top of their byte slot.
  assign payload = {5'b0, weight_a, 5'b0, weight_b, 6'b0, leak_config,
                    threshold_min, threshold_max, extra1, extra2};

  // NOTE: every variable gets its hold value before any branch, so no path
  // through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    sdata_d  = sdata_q;
    lden_d   = lden_q;
    busy_d   = busy_q;
    done_d   = done_q;
    parity_d = parity_q;

    if (enable) begin
      unique case (state_q)
        IDLE: begin
          sdata_d = 1'b0;
          lden_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          if (start) begin
            shreg_d  = payload;
            parity_d = ^payload;
            cnt_d    = '0;
            lden_d   = 1'b1;
            busy_d   = 1'b1;
            state_d  = LEAD;
          end
        end

        // The lead cycle's data bit is a don't-care driven 0; its edge
        // already presents the first payload bit for the next cycle.
        LEAD: begin
          sdata_d = shreg_q[55];
          shreg_d = {shreg_q[54:0], 1'b0};
          cnt_d   = '0;
          state_d = SHIFT;
        end

        SHIFT: begin
          if (cnt_q == LAST_BIT) begin
            sdata_d = 1'b0;
            lden_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = GAP;
          end else begin
            sdata_d = shreg_q[55];
            shreg_d = {shreg_q[54:0], 1'b0};
            cnt_d   = cnt_q + 6'd1;
          end
        end

        GAP: begin
          done_d = 1'b0;
          if (cnt_q == GAP_LAST) begin
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      sdata_q  <= 1'b0;
      lden_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      sdata_q  <= sdata_d;
      lden_q   <= lden_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      parity_q <= parity_d;
    end
  end

  assign serial_data_out = sdata_q;
  assign load_enable_out = lden_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign frame_parity    = parity_q;

endmodule
